// File: rtl/quadrant_finder.sv
// Registered quadrant classifier for a signed relative (x, y) position, one clock of latency.
// Optional axis/origin flags are built when QUADRANT_FINDER_AXIS_FLAGS_EN is defined.

package Position_PKG;
    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } PosQuadrant_t;
endpackage

module quadrant_finder #(
    parameter int NUM_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BITS-1:0]        relative_x,
    input  logic [NUM_BITS-1:0]        relative_y,
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
    output logic                       on_x_axis,
    output logic                       on_y_axis,
    output logic                       at_origin,
`endif
    output Position_PKG::PosQuadrant_t quadrant
);
    import Position_PKG::*;

    logic         sign_x;
    logic         sign_y;
    PosQuadrant_t quadrant_next;

    assign sign_x = relative_x[NUM_BITS-1];
    assign sign_y = relative_y[NUM_BITS-1];

    // Zero is non-negative, so only the sign bits decide the quadrant.
    always_comb begin
        quadrant_next = Q1;
        unique case ({sign_x, sign_y})
            2'b00:   quadrant_next = Q1;
            2'b10:   quadrant_next = Q2;
            2'b11:   quadrant_next = Q3;
            2'b01:   quadrant_next = Q4;
            default: quadrant_next = Q1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quadrant <= Q1;
        end else begin
            quadrant <= quadrant_next;
        end
    end

`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
    logic x_zero;
    logic y_zero;

    assign x_zero = (relative_x == '0);
    assign y_zero = (relative_y == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            on_x_axis <= 1'b0;
            on_y_axis <= 1'b0;
            at_origin <= 1'b0;
        end else begin
            on_x_axis <= y_zero;
            on_y_axis <= x_zero;
            at_origin <= x_zero && y_zero;
        end
    end
`else
    // Magnitude bits only matter for the axis flags; collapse them so they read as intentionally unused.
    logic unused_magnitude;
    assign unused_magnitude = ^{relative_x[NUM_BITS-2:0], relative_y[NUM_BITS-2:0]};
`endif

endmodule

// File: tb/tb_quadrant_finder.sv
// Directed bench for quadrant_finder (NUM_BITS=8): reset, each quadrant, boundaries, latency and reset override.
// Axis flag checks are compiled in when QUADRANT_FINDER_AXIS_FLAGS_EN is defined.

module tb_quadrant_finder;
    localparam int NUM_BITS = 8;
    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_BITS-1:0] relative_x;
    logic [NUM_BITS-1:0] relative_y;
    Position_PKG::PosQuadrant_t quadrant;
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
    logic on_x_axis;
    logic on_y_axis;
    logic at_origin;
`endif

    int passed = 0;
    int total  = 0;

    quadrant_finder #(.NUM_BITS(NUM_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .relative_x (relative_x),
        .relative_y (relative_y),
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
        .on_x_axis  (on_x_axis),
        .on_y_axis  (on_y_axis),
        .at_origin  (at_origin),
`endif
        .quadrant   (quadrant)
    );

    always #5 clk = ~clk;

    task automatic check_q(input string tag, input logic [1:0] expected);
        logic [1:0] observed;
        observed = quadrant;
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: quadrant observed %0d expected %0d", tag, observed, expected);
    endtask

`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
    task automatic check_flags(input string tag, input logic [2:0] expected);
        logic [2:0] observed;
        observed = {at_origin, on_x_axis, on_y_axis};
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: {origin,x_axis,y_axis} observed %b expected %b", tag, observed, expected);
    endtask
`endif

    // Drive on the falling edge, then sample 1 time unit after the second rising edge.
    task automatic apply(input int x, input int y);
        @(negedge clk);
        relative_x = NUM_BITS'(x);
        relative_y = NUM_BITS'(y);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        relative_x = NUM_BITS'(-5);
        relative_y = NUM_BITS'(-4);
        @(posedge clk); #1;
        check_q("reset_edge1", Q1);
        @(posedge clk); #1;
        check_q("reset_edge2", Q1);
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
        check_flags("reset_flags", 3'b000);
`endif
        @(negedge clk);
        reset = 1'b0;

        apply(0, 0);
        check_q("origin", Q1);
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
        check_flags("origin_flags", 3'b111);
`endif
        apply(1, 2);
        check_q("q1_1_2", Q1);
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
        check_flags("q1_flags", 3'b000);
`endif
        apply(-4, 2);
        check_q("q2_m4_2", Q2);
        apply(-5, -4);
        check_q("q3_m5_m4", Q3);
        apply(2, -2);
        check_q("q4_2_m2", Q4);
        apply(-128, 127);
        check_q("bound_m128_127", Q2);
        apply(127, -128);
        check_q("bound_127_m128", Q4);
        apply(0, -1);
        check_q("bound_0_m1", Q4);
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
        check_flags("y_axis_flags", 3'b001);
`endif
        apply(-1, 0);
        check_q("bound_m1_0", Q2);
`ifdef QUADRANT_FINDER_AXIS_FLAGS_EN
        check_flags("x_axis_flags", 3'b010);
`endif

        // Latency: old result holds until the edge that samples the new input.
        apply(1, 2);
        check_q("lat_settle", Q1);
        @(negedge clk);
        relative_x = NUM_BITS'(-5);
        relative_y = NUM_BITS'(-4);
        #1;
        check_q("lat_before_edge", Q1);
        @(posedge clk); #1;
        check_q("lat_after_edge", Q3);

        // Reset on the same edge as an input change wins.
        @(negedge clk);
        reset      = 1'b1;
        relative_x = NUM_BITS'(2);
        relative_y = NUM_BITS'(-2);
        @(posedge clk); #1;
        check_q("reset_override", Q1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_q("reset_release_hold", Q1);
        @(posedge clk); #1;
        check_q("post_reset_first", Q4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
